intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt controller directly upstream of the single-cycle interrupt-capable CPU.
- Collects up to NIRQ external interrupt lines and drives the CPU's single `intr` request.
- Consumes the CPU's one-cycle `inta` acknowledge and latches the winning source ID into a vector register.
- The handler reads that register over a small memory-mapped port. It then writes end-of-interrupt (EOI) before the next request can be raised.

Parameters:
- NIRQ, 8, number of interrupt sources (1..32). Index 0 has the highest priority.

Ports:
- clock  in  1  system clock; rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- irq_in  in  NIRQ  raw asynchronous interrupt lines; a rising edge raises a request.
- intr  out  1  interrupt request to CPU.
- inta  in  1  CPU acknowledge; one-cycle pulse when the CPU takes the interrupt.
- sel  in  1  register-port select (address decode done outside).
- we  in  1  write enable, qualified by sel.
- addr  in  2  register word index (CPU address bits [3:2]).
- wdata  in  32  write data (CPU store data).
- rdata  out  32  read data; combinational from addr.

Behaviour:
- Reset (resetn=0, asynchronous):
  - all synchronisers, edge registers, pending and mask bits clear;
  - state=IDLE, vector=0, intr=0, rdata reflects the cleared registers.
- Input path per line:
  - two-flop synchroniser, then a previous-value register;
  - edge = sync2 & ~prev.
  - irq_in rising before clock edge 1 sets pending[i] at edge 3. intr is high after edge 3 if enabled.
  - A level held high gives exactly one pending set. A pulse shorter than one clock may be lost.
- intr = (state==IDLE) & |(pending & mask). Combinational from registers, no extra latency.
- State machine, two states:
  - IDLE: on inta=1 with intr=1:
    - winner = lowest index i with pending[i]&mask[i];
    - vector <= {valid=1, id=i};
    - pending[i] cleared;
    - state <= SERVICE.
  - IDLE: inta=1 with intr=0 is spurious. It is ignored; vector and state are unchanged.
  - SERVICE: intr forced 0. Pending bits keep accumulating.
  - SERVICE: a write to EOI sets state <= IDLE and clears vector.valid; vector.id is retained.
  - SERVICE: inta is ignored.
  - IDLE: an EOI write is ignored.
- Register map (addr):
  - 0 MASK: rw; bits [NIRQ-1:0]; upper bits read 0.
  - 1 PENDING: read raw pending; write-1-to-clear.
  - 2 VECTOR: ro; bit31=valid, bits[4:0]=id, others 0.
  - 3 EOI: wo, any data; reads 0.
  - Writes take effect at the next clock edge when sel&we.
- Simultaneous events:
  - Edge and W1C on the same bit, same cycle: set wins, bit stays 1.
  - Edge on source i in the same cycle inta selects i: the pending bit stays 1 (new request is not lost). Vector still latches i.
  - MASK write and inta in the same cycle: the winner uses the old mask.
  - EOI write and new pending in the same cycle: state=IDLE next cycle, and intr rises then if the request is enabled.
- Masked sources still latch pending. Unmasking later raises intr immediately (next cycle after the MASK write).
- Reset mid-SERVICE returns to IDLE with everything cleared. The in-flight request is discarded.

Decomposition:
- Shared package/include holds:
  - register index constants: INTC_MASK=0, INTC_PEND=1, INTC_VEC=2, INTC_EOI=3;
  - the VECTOR valid bit position (31);
  - state encodings IDLE/SERVICE.
- One natural sub-module: intr_sync_edge. It is the per-line 2-flop synchroniser plus rising-edge detector, instantiated NIRQ times via generate.
- Priority encoder stays inline as a for-loop from high index down to 0.

Test Plan:
- Reset:
  - Stimulus: assert resetn=0 mid-run with irq_in=8'hFF, mask=8'hFF.
  - Response: intr=0, MASK/PEND/VEC read 0 immediately. After release, with lines held high, no pending sets.
- Single request:
  - Stimulus: MASK=8'h08, pulse irq_in[3] for 2 cycles.
  - Response: intr=1 after edge 3. inta pulse gives VEC=32'h8000_0003, PEND=0, intr=0. EOI write gives VEC=32'h0000_0003, intr stays 0.
- Priority:
  - Stimulus: MASK=8'hFF, rise irq_in[5] and irq_in[2] together, inta.
  - Response: VEC id=2, PEND=8'h20. After EOI, intr=1 next cycle. Second inta gives id=5.
- Masking:
  - Stimulus: MASK=8'h00, rise irq_in[7].
  - Response: PEND=8'h80, intr=0. Write MASK=8'h80 and intr=1 next cycle.
- Collisions:
  - Same-cycle W1C of bit 1 and a new edge on bit 1 leaves PEND bit1=1.
  - inta selecting 4 while a new edge arrives on 4 gives VEC id=4, PEND bit4=1.
- Spurious and EOI-in-IDLE:
  - Stimulus: inta with intr=0; then EOI in IDLE.
  - Response: VEC unchanged (0), state IDLE, no side effects.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
//   - register word indices of the memory-mapped port
//   - VECTOR register layout
//   - controller state encoding
//   - start-up blanking length for the edge detectors
package intr_ctrl_pkg;

  localparam logic [1:0] INTC_MASK = 2'd0;
  localparam logic [1:0] INTC_PEND = 2'd1;
  localparam logic [1:0] INTC_VEC  = 2'd2;
  localparam logic [1:0] INTC_EOI  = 2'd3;

  localparam int VEC_VALID_BIT = 31;
  localparam int ID_W          = 5;

  // Cycles after reset release during which detected edges are discarded,
  // long enough for sync2 and prev to both hold real samples of the line.
  localparam logic [1:0] BLANK_CYCLES = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } intc_state_t;

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-facing signals of the interrupt controller: interrupt request and
// acknowledge handshake plus the small register port.
//   intr  : request to CPU
//   inta  : one-cycle acknowledge from CPU
//   sel   : register-port select
//   we    : write enable (qualified by sel)
//   addr  : register word index
//   wdata : write data
//   rdata : read data, combinational from addr
// master = CPU side, slave = controller side.
interface intr_ctrl_if;
  logic        intr;
  logic        inta;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output inta, sel, we, addr, wdata, input intr, rdata);
  modport slave  (input inta, sel, we, addr, wdata, output intr, rdata);
endinterface

// File: rtl/intr_sync_edge.sv
// Per-line input conditioning: two-flop synchroniser followed by a
// previous-value register; irq_edge pulses for one cycle on a rising edge.
//   clock    : system clock
//   resetn   : async active-low reset
//   irq_raw  : asynchronous interrupt line
//   irq_edge : one-cycle rising-edge pulse (combinational from flops)
module intr_sync_edge (
  input  logic clock,
  input  logic resetn,
  input  logic irq_raw,
  output logic irq_edge
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= irq_raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign irq_edge = sync2 & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: collects NIRQ edge-triggered lines, raises intr to
// the CPU, latches the winning source on inta and waits for EOI.
//   clock  : system clock
//   resetn : async active-low reset
//   irq_in : raw interrupt lines, rising edge raises a request
//   bus    : CPU handshake and register port (slave side)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | intr may be raised; inta latches the winner into VECTOR
// SERVICE | handler running; intr held low until an EOI write
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NIRQ = 8
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [NIRQ-1:0] irq_in,
  intr_ctrl_if.slave      bus
);

  logic [NIRQ-1:0] irq_edge;
  logic [NIRQ-1:0] edge_q;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] req;
  logic [NIRQ-1:0] w1c;
  logic [NIRQ-1:0] ack_clr;
  logic [1:0]      blank_cnt;
  logic            armed;
  intc_state_t     state;
  logic            vec_valid;
  logic [ID_W-1:0] vec_id;
  logic            win_hit;
  logic [ID_W-1:0] win_id;
  logic            intr_c;
  logic            ack;
  logic            wr_mask;
  logic            wr_pend;
  logic            wr_eoi;
  logic [31:0]     rdata_c;
  logic            unused_wdata;

  for (genvar g = 0; g < NIRQ; g++) begin : g_line
    intr_sync_edge u_sync (
      .clock    (clock),
      .resetn   (resetn),
      .irq_raw  (irq_in[g]),
      .irq_edge (irq_edge[g])
    );
  end

  // After reset the edge registers are zero, so a line already high would
  // look like a fresh edge. Blank detection until prev tracks the line.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      blank_cnt <= BLANK_CYCLES;
    end else if (blank_cnt != 2'd0) begin
      blank_cnt <= blank_cnt - 2'd1;
    end
  end

  assign armed  = (blank_cnt == 2'd0);
  assign edge_q = armed ? irq_edge : '0;

  assign wr_mask = bus.sel & bus.we & (bus.addr == INTC_MASK);
  assign wr_pend = bus.sel & bus.we & (bus.addr == INTC_PEND);
  assign wr_eoi  = bus.sel & bus.we & (bus.addr == INTC_EOI);

  assign req = pending & mask;

  // Lowest index wins: scanning downwards leaves the smallest hit last.
  always_comb begin
    win_hit = 1'b0;
    win_id  = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_hit = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end

  assign intr_c  = (state == IDLE) & win_hit;
  assign ack     = bus.inta & intr_c;
  assign w1c     = wr_pend ? bus.wdata[NIRQ-1:0] : '0;
  assign ack_clr = ack ? (NIRQ'(1) << win_id) : '0;

  // Clears are applied first so a same-cycle edge always survives.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~(w1c | ack_clr)) | edge_q;
      if (wr_mask) begin
        mask <= bus.wdata[NIRQ-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      vec_valid <= 1'b0;
      vec_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ack) begin
            vec_valid <= 1'b1;
            vec_id    <= win_id;
            state     <= SERVICE;
          end
        end
        SERVICE: begin
          if (wr_eoi) begin
            vec_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata_c = '0;
    case (bus.addr)
      INTC_MASK: rdata_c[NIRQ-1:0] = mask;
      INTC_PEND: rdata_c[NIRQ-1:0] = pending;
      INTC_VEC: begin
        rdata_c[VEC_VALID_BIT] = vec_valid;
        rdata_c[ID_W-1:0]      = vec_id;
      end
      default: rdata_c = '0;
    endcase
  end

  // intr must follow the registers with no added latency, so it is not
  // re-registered.
  assign bus.intr  = intr_c;
  assign bus.rdata = rdata_c;

  assign unused_wdata = ^bus.wdata;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  logic       clock;
  logic       resetn;
  logic [7:0] irq_in;
  int         errors;
  int         checks;
  logic [31:0] rv;

  intr_ctrl_if bus ();

  intr_ctrl #(.NIRQ(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .irq_in (irq_in),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clock);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clock);
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic pulse_inta();
    bus.inta = 1'b1;
    @(negedge clock);
    bus.inta = 1'b0;
  endtask

  task automatic test_reset();
    wr(INTC_MASK, 32'hFF);
    irq_in = 8'hFF;
    cycles(3);
    checks++;
    if (bus.intr !== 1'b1) begin
      errors++; $display("FAIL rst_pre_intr actual=%b required=1", bus.intr);
    end
    pulse_inta();
    rd(INTC_VEC, rv);
    checks++;
    if (rv !== 32'h8000_0000) begin
      errors++; $display("FAIL rst_pre_vec actual=%h required=80000000", rv);
    end
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (bus.intr !== 1'b0) begin
      errors++; $display("FAIL rst_intr actual=%b required=0", bus.intr);
    end
    rd(INTC_MASK, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL rst_mask actual=%h required=00000000", rv);
    end
    rd(INTC_PEND, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL rst_pend actual=%h required=00000000", rv);
    end
    rd(INTC_VEC, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL rst_vec actual=%h required=00000000", rv);
    end
    @(negedge clock);
    #2 resetn = 1'b1;
    @(negedge clock);
    cycles(6);
    rd(INTC_PEND, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL rst_held_pend actual=%h required=00000000", rv);
    end
    checks++;
    if (bus.intr !== 1'b0) begin
      errors++; $display("FAIL rst_held_intr actual=%b required=0", bus.intr);
    end
    irq_in = 8'h00;
    cycles(4);
  endtask

  task automatic test_spurious();
    checks++;
    if (bus.intr !== 1'b0) begin
      errors++; $display("FAIL spur_pre_intr actual=%b required=0", bus.intr);
    end
    pulse_inta();
    rd(INTC_VEC, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL spur_vec actual=%h required=00000000", rv);
    end
    wr(INTC_EOI, 32'hDEAD_BEEF);
    rd(INTC_VEC, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL eoi_idle_vec actual=%h required=00000000", rv);
    end
    rd(INTC_EOI, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL eoi_read actual=%h required=00000000", rv);
    end
    // still IDLE: a fresh enabled request must raise intr
    wr(INTC_MASK, 32'h01);
    irq_in = 8'h01;
    cycles(3);
    checks++;
    if (bus.intr !== 1'b1) begin
      errors++; $display("FAIL spur_idle_intr actual=%b required=1", bus.intr);
    end
    pulse_inta();
    wr(INTC_EOI, 32'h0);
    irq_in = 8'h00;
    cycles(4);
  endtask

  task automatic test_single();
    wr(INTC_MASK, 32'h08);
    irq_in[3] = 1'b1;
    cycles(2);
    checks++;
    if (bus.intr !== 1'b0) begin
      errors++; $display("FAIL single_early_intr actual=%b required=0", bus.intr);
    end
    irq_in[3] = 1'b0;
    cycles(1);
    checks++;
    if (bus.intr !== 1'b1) begin
      errors++; $display("FAIL single_intr actual=%b required=1", bus.intr);
    end
    pulse_inta();
    rd(INTC_VEC, rv);
    checks++;
    if (rv !== 32'h8000_0003) begin
      errors++; $display("FAIL single_vec actual=%h required=80000003", rv);
    end
    rd(INTC_PEND, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL single_pend actual=%h required=00000000", rv);
    end
    checks++;
    if (bus.intr !== 1'b0) begin
      errors++; $display("FAIL single_svc_intr actual=%b required=0", bus.intr);
    end
    wr(INTC_EOI, 32'h0);
    rd(INTC_VEC, rv);
    checks++;
    if (rv !== 32'h0000_0003) begin
      errors++; $display("FAIL single_eoi_vec actual=%h required=00000003", rv);
    end
    checks++;
    if (bus.intr !== 1'b0) begin
      errors++; $display("FAIL single_eoi_intr actual=%b required=0", bus.intr);
    end
    cycles(2);
  endtask

  task automatic test_priority();
    wr(INTC_MASK, 32'hFF);
    irq_in = 8'h24;
    cycles(3);
    pulse_inta();
    rd(INTC_VEC, rv);
    checks++;
    if (rv !== 32'h8000_0002) begin
      errors++; $display("FAIL prio_vec1 actual=%h required=80000002", rv);
    end
    rd(INTC_PEND, rv);
    checks++;
    if (rv !== 32'h20) begin
      errors++; $display("FAIL prio_pend1 actual=%h required=00000020", rv);
    end
    irq_in = 8'h00;
    wr(INTC_EOI, 32'h0);
    checks++;
    if (bus.intr !== 1'b1) begin
      errors++; $display("FAIL prio_eoi_intr actual=%b required=1", bus.intr);
    end
    pulse_inta();
    rd(INTC_VEC, rv);
    checks++;
    if (rv !== 32'h8000_0005) begin
      errors++; $display("FAIL prio_vec2 actual=%h required=80000005", rv);
    end
    rd(INTC_PEND, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL prio_pend2 actual=%h required=00000000", rv);
    end
    wr(INTC_EOI, 32'h0);
    cycles(2);
  endtask

  task automatic test_masking();
    wr(INTC_MASK, 32'h00);
    irq_in[7] = 1'b1;
    cycles(3);
    rd(INTC_PEND, rv);
    checks++;
    if (rv !== 32'h80) begin
      errors++; $display("FAIL mask_pend actual=%h required=00000080", rv);
    end
    checks++;
    if (bus.intr !== 1'b0) begin
      errors++; $display("FAIL mask_intr_off actual=%b required=0", bus.intr);
    end
    wr(INTC_MASK, 32'h80);
    checks++;
    if (bus.intr !== 1'b1) begin
      errors++; $display("FAIL mask_intr_on actual=%b required=1", bus.intr);
    end
    rd(INTC_MASK, rv);
    checks++;
    if (rv !== 32'h80) begin
      errors++; $display("FAIL mask_read actual=%h required=00000080", rv);
    end
    pulse_inta();
    wr(INTC_EOI, 32'h0);
    irq_in = 8'h00;
    cycles(4);
  endtask

  task automatic test_collision();
    // W1C on bit 1 lands on the same edge that sets it
    wr(INTC_MASK, 32'h00);
    irq_in[1] = 1'b1;
    cycles(2);
    wr(INTC_PEND, 32'h02);
    rd(INTC_PEND, rv);
    checks++;
    if (rv !== 32'h02) begin
      errors++; $display("FAIL coll_w1c_pend actual=%h required=00000002", rv);
    end
    wr(INTC_PEND, 32'h02);
    rd(INTC_PEND, rv);
    checks++;
    if (rv !== 32'h0) begin
      errors++; $display("FAIL w1c_pend actual=%h required=00000000", rv);
    end
    irq_in[1] = 1'b0;
    cycles(4);
    // inta picks source 4 on the same edge a new request on 4 arrives
    wr(INTC_MASK, 32'hFF);
    irq_in[4] = 1'b1;
    cycles(3);
    irq_in[4] = 1'b0;
    cycles(4);
    irq_in[4] = 1'b1;
    cycles(2);
    pulse_inta();
    rd(INTC_VEC, rv);
    checks++;
    if (rv !== 32'h8000_0004) begin
      errors++; $display("FAIL coll_ack_vec actual=%h required=80000004", rv);
    end
    rd(INTC_PEND, rv);
    checks++;
    if (rv !== 32'h10) begin
      errors++; $display("FAIL coll_ack_pend actual=%h required=00000010", rv);
    end
    wr(INTC_EOI, 32'h0);
    checks++;
    if (bus.intr !== 1'b1) begin
      errors++; $display("FAIL coll_eoi_intr actual=%b required=1", bus.intr);
    end
    pulse_inta();
    wr(INTC_EOI, 32'h0);
    irq_in = 8'h00;
    cycles(4);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    resetn    = 1'b0;
    irq_in    = 8'h00;
    bus.inta  = 1'b0;
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 32'h0;
    #22 resetn = 1'b1;
    @(negedge clock);
    cycles(5);
    test_reset();
    test_spurious();
    test_single();
    test_priority();
    test_masking();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
